// File: rtl/lc3b_mem_sequencer_pkg.sv
// lc3b_mem_sequencer_pkg
//   Shared types and width helpers for the load/store sequencer.
//   - lc3b_seq_err   : response error code reported alongside resp_valid
//   - lc3b_seq_state : sequencer FSM states
//   - SEQ_TIMEOUT_W  : width of the per-access wait counter for a given TIMEOUT
//   - SEQ_IND_W      : width of the indirection count for a given MAX_INDIRECT
package lc3b_mem_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_OK       = 2'b00,
    SEQ_MISALIGN = 2'b01,
    SEQ_TIMEOUT  = 2'b10,
    SEQ_BADIND   = 2'b11
  } lc3b_seq_err;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_IND_RD  = 3'd2,
    ST_DATA_RD = 3'd3,
    ST_DATA_WR = 3'd4,
    ST_RESP    = 3'd5
  } lc3b_seq_state;

  // Wait counter must be able to hold TIMEOUT itself; a disabled timeout still needs one bit.
  function automatic int SEQ_TIMEOUT_W(input int timeout);
    if (timeout < 1) begin
      return 1;
    end else begin
      return $clog2(timeout + 1);
    end
  endfunction

  // Dereference count width, never narrower than one bit.
  function automatic int SEQ_IND_W(input int max_ind);
    if (max_ind < 1) begin
      return 1;
    end else begin
      return $clog2(max_ind + 1);
    end
  endfunction

endpackage

// File: rtl/lc3b_mem_sequencer_byte_lane.sv
// lc3b_byte_lane
//   Combinational byte-lane steering for sub-word accesses.
//   Ports:
//     byte_mode  in  1             1 = byte access, 0 = full word (pass-through)
//     lane       in  LB            selected byte lane (low address bits)
//     wdata      in  DATA_WIDTH    store data; byte stores use bits [7:0]
//     rdata      in  DATA_WIDTH    raw memory read data
//     wdata_lane out DATA_WIDTH    write data, byte replicated to every lane in byte mode
//     rdata_lane out DATA_WIDTH    read data, selected byte zero-extended in byte mode
//     byte_en    out DATA_WIDTH/8  lane enables: one-hot in byte mode, all ones otherwise
module lc3b_byte_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                                  byte_mode,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]       lane,
  input  logic [DATA_WIDTH-1:0]                 wdata,
  input  logic [DATA_WIDTH-1:0]                 rdata,
  output logic [DATA_WIDTH-1:0]                 wdata_lane,
  output logic [DATA_WIDTH-1:0]                 rdata_lane,
  output logic [DATA_WIDTH/8-1:0]               byte_en
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);

  // Lane select, replicate and enable generation.
  always_comb begin
    wdata_lane = wdata;
    rdata_lane = rdata;
    byte_en    = {NB{1'b1}};
    if (byte_mode) begin
      rdata_lane = {{(DATA_WIDTH-8){1'b0}}, rdata[{lane, 3'b000} +: 8]};
      for (int i = 0; i < NB; i++) begin
        wdata_lane[8*i +: 8] = wdata[7:0];
        byte_en[i]           = (lane == LB'(i));
      end
    end else begin
      wdata_lane = wdata;
      rdata_lane = rdata;
      byte_en    = {NB{1'b1}};
    end
  end

endmodule

// File: rtl/lc3b_mem_sequencer.sv
// lc3b_mem_sequencer
//   Runs one memory transaction per accepted request: word/byte load or store, optionally
//   preceded by up to MAX_INDIRECT pointer dereferences, with wait states, timeout and
//   misalignment detection.
//   Ports:
//     clk, rst                      clock (rising edge), asynchronous active-high reset
//     req_valid/req_ready           request handshake; fields latched on acceptance
//     req_write/req_byte/req_ind    store flag, byte flag, dereference count
//     req_addr/req_wdata            byte address (or pointer address) and store data
//     resp_valid/rdata/error        one-cycle completion pulse with load data and error code
//     mem_read/mem_write            registered strobes, held until mem_resp or timeout
//     mem_address/wdata/byte_enable registered word-aligned address, data and lane enables
//     mem_rdata/mem_resp            memory read data and one-cycle completion
module lc3b_mem_sequencer
  import lc3b_mem_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int MAX_INDIRECT = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic                               req_byte,
  input  logic [SEQ_IND_W(MAX_INDIRECT)-1:0] req_ind,
  input  logic [ADDR_WIDTH-1:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]              req_wdata,
  output logic                               resp_valid,
  output logic [DATA_WIDTH-1:0]              resp_rdata,
  output logic [1:0]                         resp_error,
  output logic                               mem_read,
  output logic                               mem_write,
  output logic [ADDR_WIDTH-1:0]              mem_address,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  output logic [DATA_WIDTH/8-1:0]            mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]              mem_rdata,
  input  logic                               mem_resp
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = SEQ_IND_W(MAX_INDIRECT);
  localparam int TW = SEQ_TIMEOUT_W(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  lc3b_seq_state state_r, state_n;
  lc3b_seq_err   err_n;

  logic                  write_r;
  logic                  byte_r;
  logic [IW-1:0]         cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [TW-1:0]         wait_r;

  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [ADDR_WIDTH-1:0] ptr_s;
  logic                  timeout_s;
  logic                  mem_read_s;
  logic                  mem_write_s;
  logic [DATA_WIDTH-1:0] wdata_lane_s;
  logic [DATA_WIDTH-1:0] rdata_lane_s;
  logic [NB-1:0]         byte_en_s;

  logic                  mem_read_r;
  logic                  mem_write_r;
  logic [ADDR_WIDTH-1:0] mem_address_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [NB-1:0]         mem_byte_enable_r;
  logic                  resp_valid_r;
  logic [1:0]            resp_error_r;
  logic [DATA_WIDTH-1:0] resp_rdata_r;

  // A loaded pointer is the memory word resized to the address width.
  assign ptr_s     = ADDR_WIDTH'(mem_rdata);
  // The last allowed waiting cycle; mem_resp in that cycle still wins.
  assign timeout_s = TO_EN && (wait_r == TO_LAST);

  // Lane steering follows the address of the access being set up (the freshly loaded
  // pointer when leaving the last dereference), which equals addr_r during a data read.
  lc3b_byte_lane #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_byte_lane (
    .byte_mode  (byte_r),
    .lane       (next_addr_s[LB-1:0]),
    .wdata      (wdata_r),
    .rdata      (mem_rdata),
    .wdata_lane (wdata_lane_s),
    .rdata_lane (rdata_lane_s),
    .byte_en    (byte_en_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state, error code and next access address.
  always_comb begin
    state_n     = state_r;
    err_n       = SEQ_OK;
    next_addr_s = addr_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_n = ST_CHECK;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (int'(cnt_r) > MAX_INDIRECT) begin
          state_n = ST_RESP;
          err_n   = SEQ_BADIND;
        end else if (!byte_r && (addr_r[LB-1:0] != {LB{1'b0}})) begin
          state_n = ST_RESP;
          err_n   = SEQ_MISALIGN;
        end else if (cnt_r != {IW{1'b0}}) begin
          state_n = ST_IND_RD;
        end else if (write_r) begin
          state_n = ST_DATA_WR;
        end else begin
          state_n = ST_DATA_RD;
        end
      end
      ST_IND_RD: begin
        if (mem_resp) begin
          next_addr_s = ptr_s;
          if (!byte_r && (ptr_s[LB-1:0] != {LB{1'b0}})) begin
            state_n = ST_RESP;
            err_n   = SEQ_MISALIGN;
          end else if (cnt_r == IW'(1)) begin
            state_n = write_r ? ST_DATA_WR : ST_DATA_RD;
          end else begin
            state_n = ST_IND_RD;
          end
        end else if (timeout_s) begin
          state_n = ST_RESP;
          err_n   = SEQ_TIMEOUT;
        end else begin
          state_n = ST_IND_RD;
        end
      end
      ST_DATA_RD, ST_DATA_WR: begin
        if (mem_resp) begin
          state_n = ST_RESP;
        end else if (timeout_s) begin
          state_n = ST_RESP;
          err_n   = SEQ_TIMEOUT;
        end else begin
          state_n = state_r;
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Strobe decode for the state being entered; registered below so strobes are glitch-free.
  always_comb begin
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    case (state_n)
      ST_IND_RD, ST_DATA_RD: mem_read_s  = 1'b1;
      ST_DATA_WR:            mem_write_s = 1'b1;
      default: begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
      end
    endcase
  end

  // Request latch, pointer/count update and per-access wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_r <= 1'b0;
      byte_r  <= 1'b0;
      cnt_r   <= {IW{1'b0}};
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
      wait_r  <= {TW{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && req_valid) begin
        write_r <= req_write;
        byte_r  <= req_byte;
        cnt_r   <= req_ind;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end else if ((state_r == ST_IND_RD) && mem_resp) begin
        addr_r <= ptr_s;
        cnt_r  <= cnt_r - IW'(1);
      end
      // Counter restarts whenever a response arrives or a memory state is entered.
      if (((state_r == ST_IND_RD) || (state_r == ST_DATA_RD) || (state_r == ST_DATA_WR)) && !mem_resp) begin
        wait_r <= wait_r + TW'(1);
      end else begin
        wait_r <= {TW{1'b0}};
      end
    end
  end

  // Registered memory-side and response-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read_r        <= 1'b0;
      mem_write_r       <= 1'b0;
      mem_address_r     <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r       <= {DATA_WIDTH{1'b0}};
      mem_byte_enable_r <= {NB{1'b1}};
      resp_valid_r      <= 1'b0;
      resp_error_r      <= 2'b00;
      resp_rdata_r      <= {DATA_WIDTH{1'b0}};
    end else begin
      mem_read_r        <= mem_read_s;
      mem_write_r       <= mem_write_s;
      mem_byte_enable_r <= mem_write_s ? byte_en_s : {NB{1'b1}};
      resp_valid_r      <= (state_n == ST_RESP);
      if (mem_read_s || mem_write_s) begin
        mem_address_r <= {next_addr_s[ADDR_WIDTH-1:LB], {LB{1'b0}}};
      end
      if (mem_write_s) begin
        mem_wdata_r <= wdata_lane_s;
      end
      if ((state_n == ST_RESP) && (state_r != ST_RESP)) begin
        resp_error_r <= err_n;
        resp_rdata_r <= ((state_r == ST_DATA_RD) && mem_resp) ? rdata_lane_s : {DATA_WIDTH{1'b0}};
      end
    end
  end

  assign req_ready       = (state_r == ST_IDLE);
  assign resp_valid      = resp_valid_r;
  assign resp_error      = resp_error_r;
  assign resp_rdata      = resp_rdata_r;
  assign mem_read        = mem_read_r;
  assign mem_write       = mem_write_r;
  assign mem_address     = mem_address_r;
  assign mem_wdata       = mem_wdata_r;
  assign mem_byte_enable = mem_byte_enable_r;

endmodule

// File: tb/tb_lc3b_mem_sequencer.sv
// tb_lc3b_mem_sequencer
//   Directed bench for lc3b_mem_sequencer (16-bit data/address, MAX_INDIRECT=2, TIMEOUT=8).
//   A memory responder answers each access after a configurable number of wait cycles and
//   logs every access it sees; scenario tasks compare against hand-computed values.
module tb_lc3b_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [1:0]  req_ind;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [1:0]  resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  int checks = 0;
  int errors = 0;

  // responder configuration and access log
  int          waits;
  bit          resp_on;
  logic [15:0] rd_q [8];
  int          rd_idx;
  int          wcnt;
  int          acc_n;
  logic [15:0] acc_addr  [16];
  logic        acc_wr    [16];
  logic [15:0] acc_wdata [16];
  logic [1:0]  acc_be    [16];
  int          strobe_cyc;
  int          both_hi;
  int          resp_pulses;

  // results of the last do_req
  int          lat;
  logic [15:0] rdat;
  logic [1:0]  rerr;

  lc3b_mem_sequencer #(
    .DATA_WIDTH   (16),
    .ADDR_WIDTH   (16),
    .MAX_INDIRECT (2),
    .TIMEOUT      (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_byte        (req_byte),
    .req_ind         (req_ind),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_error      (resp_error),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  always #5 clk = ~clk;

  // Memory responder: answers after 'waits' strobe cycles, logs the start of each access.
  always @(negedge clk) begin
    if (rst) begin
      mem_resp = 1'b0;
      wcnt     = 0;
    end else if (mem_read || mem_write) begin
      strobe_cyc++;
      if (mem_read && mem_write) both_hi++;
      if (wcnt == 0 && acc_n < 16) begin
        acc_addr[acc_n]  = mem_address;
        acc_wr[acc_n]    = mem_write;
        acc_wdata[acc_n] = mem_wdata;
        acc_be[acc_n]    = mem_byte_enable;
        acc_n++;
      end
      if (resp_on && wcnt == waits) begin
        mem_resp  = 1'b1;
        mem_rdata = rd_q[rd_idx % 8];
        rd_idx++;
        wcnt = 0;
      end else begin
        mem_resp = 1'b0;
        wcnt++;
      end
    end else begin
      mem_resp = 1'b0;
      wcnt     = 0;
    end
    if (resp_valid) resp_pulses++;
  end

  task automatic clear_log(input int w, input bit on);
    waits      = w;
    resp_on    = on;
    acc_n      = 0;
    strobe_cyc = 0;
    rd_idx     = 0;
  endtask

  // Issue one request, scramble the request fields after acceptance, wait for resp_valid.
  task automatic do_req(input string name, input bit w, input bit b, input logic [1:0] ind,
                        input logic [15:0] addr, input logic [15:0] wd);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_write = w;
    req_byte  = b;
    req_ind   = ind;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge clk);
    lat       = 1;
    req_valid = 1'b0;
    req_write = ~w;
    req_byte  = ~b;
    req_ind   = 2'd0;
    req_addr  = 16'hFFFF;
    req_wdata = 16'h5A5A;
    while (!resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    rdat = resp_rdata;
    rerr = resp_error;
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s resp_valid: not seen within %0d cycles", name, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_error !== 2'b00) begin errors++; $display("FAIL reset resp_error: got %b want 00", resp_error); end
    checks++; if (resp_rdata !== 16'h0000) begin errors++; $display("FAIL reset resp_rdata: got %h want 0000", resp_rdata); end
    checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset strobes: got %b want 00", {mem_read, mem_write}); end
    checks++; if (mem_address !== 16'h0000) begin errors++; $display("FAIL reset mem_address: got %h want 0000", mem_address); end
    checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset mem_wdata: got %h want 0000", mem_wdata); end
    checks++; if (mem_byte_enable !== 2'b11) begin errors++; $display("FAIL reset byte_enable: got %b want 11", mem_byte_enable); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word_load();
    clear_log(3, 1'b1);
    rd_q[0] = 16'hBEEF;
    do_req("word_load", 1'b0, 1'b0, 2'd0, 16'h3000, 16'h0000);
    checks++; if (rdat !== 16'hBEEF) begin errors++; $display("FAIL word_load rdata: got %h want BEEF", rdat); end
    checks++; if (rerr !== 2'b00) begin errors++; $display("FAIL word_load error: got %b want 00", rerr); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL word_load latency: got %0d want 6", lat); end
    checks++; if (acc_n !== 1 || acc_addr[0] !== 16'h3000 || acc_wr[0] !== 1'b0) begin errors++; $display("FAIL word_load access: n=%0d addr=%h wr=%b want 1 3000 0", acc_n, acc_addr[0], acc_wr[0]); end
    checks++; if (strobe_cyc !== 4) begin errors++; $display("FAIL word_load strobe_len: got %0d want 4", strobe_cyc); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL word_load ready_in_resp: got %b want 0", req_ready); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL word_load after_resp: valid=%b ready=%b want 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_byte_store();
    clear_log(0, 1'b1);
    rd_q[0] = 16'h7777;
    do_req("byte_store", 1'b1, 1'b1, 2'd0, 16'h4001, 16'h0BAD);
    checks++; if (acc_addr[0] !== 16'h4000 || acc_wr[0] !== 1'b1) begin errors++; $display("FAIL byte_store addr: got %h wr=%b want 4000 1", acc_addr[0], acc_wr[0]); end
    checks++; if (acc_wdata[0] !== 16'hADAD) begin errors++; $display("FAIL byte_store wdata: got %h want ADAD", acc_wdata[0]); end
    checks++; if (acc_be[0] !== 2'b10) begin errors++; $display("FAIL byte_store be: got %b want 10", acc_be[0]); end
    checks++; if (rdat !== 16'h0000 || rerr !== 2'b00) begin errors++; $display("FAIL byte_store resp: rdata=%h err=%b want 0000 00", rdat, rerr); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL byte_store latency: got %0d want 3", lat); end
    clear_log(0, 1'b1);
    do_req("word_store", 1'b1, 1'b0, 2'd0, 16'h4002, 16'h1234);
    checks++; if (acc_addr[0] !== 16'h4002 || acc_wdata[0] !== 16'h1234 || acc_be[0] !== 2'b11) begin errors++; $display("FAIL word_store: addr=%h wdata=%h be=%b want 4002 1234 11", acc_addr[0], acc_wdata[0], acc_be[0]); end
  endtask

  task automatic test_byte_load();
    clear_log(0, 1'b1);
    rd_q[0] = 16'h12F0;
    do_req("byte_load_hi", 1'b0, 1'b1, 2'd0, 16'h4001, 16'h0000);
    checks++; if (rdat !== 16'h0012) begin errors++; $display("FAIL byte_load_hi rdata: got %h want 0012", rdat); end
    checks++; if (acc_addr[0] !== 16'h4000 || acc_be[0] !== 2'b11) begin errors++; $display("FAIL byte_load_hi access: addr=%h be=%b want 4000 11", acc_addr[0], acc_be[0]); end
    clear_log(0, 1'b1);
    rd_q[0] = 16'h12F0;
    do_req("byte_load_lo", 1'b0, 1'b1, 2'd0, 16'h4000, 16'h0000);
    checks++; if (rdat !== 16'h00F0) begin errors++; $display("FAIL byte_load_lo rdata: got %h want 00F0", rdat); end
  endtask

  task automatic test_indirect();
    clear_log(0, 1'b1);
    rd_q[0] = 16'h6000; rd_q[1] = 16'h7000; rd_q[2] = 16'h1234;
    do_req("ind2", 1'b0, 1'b0, 2'd2, 16'h5000, 16'h0000);
    checks++; if (acc_n !== 3) begin errors++; $display("FAIL ind2 accesses: got %0d want 3", acc_n); end
    checks++; if (acc_addr[0] !== 16'h5000 || acc_addr[1] !== 16'h6000 || acc_addr[2] !== 16'h7000) begin errors++; $display("FAIL ind2 addrs: got %h %h %h want 5000 6000 7000", acc_addr[0], acc_addr[1], acc_addr[2]); end
    checks++; if (rdat !== 16'h1234 || rerr !== 2'b00) begin errors++; $display("FAIL ind2 resp: rdata=%h err=%b want 1234 00", rdat, rerr); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL ind2 latency: got %0d want 5", lat); end
    clear_log(0, 1'b1);
    rd_q[0] = 16'h6000; rd_q[1] = 16'h6001; rd_q[2] = 16'h9999;
    do_req("ind_misalign", 1'b0, 1'b0, 2'd2, 16'h5000, 16'h0000);
    checks++; if (rerr !== 2'b01 || rdat !== 16'h0000) begin errors++; $display("FAIL ind_misalign resp: err=%b rdata=%h want 01 0000", rerr, rdat); end
    checks++; if (acc_n !== 2 || lat !== 4) begin errors++; $display("FAIL ind_misalign accesses: n=%0d lat=%0d want 2 4", acc_n, lat); end
    clear_log(0, 1'b1);
    do_req("bad_ind", 1'b0, 1'b0, 2'd3, 16'h5000, 16'h0000);
    checks++; if (rerr !== 2'b11 || acc_n !== 0 || lat !== 2) begin errors++; $display("FAIL bad_ind: err=%b n=%0d lat=%0d want 11 0 2", rerr, acc_n, lat); end
  endtask

  task automatic test_misalign();
    clear_log(0, 1'b1);
    do_req("misalign", 1'b0, 1'b0, 2'd0, 16'h3001, 16'h0000);
    checks++; if (rerr !== 2'b01) begin errors++; $display("FAIL misalign err: got %b want 01", rerr); end
    checks++; if (strobe_cyc !== 0 || lat !== 2) begin errors++; $display("FAIL misalign no_strobe: strobes=%0d lat=%0d want 0 2", strobe_cyc, lat); end
  endtask

  task automatic test_timeout();
    clear_log(0, 1'b0);
    do_req("timeout", 1'b0, 1'b0, 2'd0, 16'h3000, 16'h0000);
    checks++; if (rerr !== 2'b10 || rdat !== 16'h0000) begin errors++; $display("FAIL timeout resp: err=%b rdata=%h want 10 0000", rerr, rdat); end
    checks++; if (strobe_cyc !== 8 || lat !== 10) begin errors++; $display("FAIL timeout length: strobes=%0d lat=%0d want 8 10", strobe_cyc, lat); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL timeout strobe_drop: got %b want 0", mem_read); end
    clear_log(7, 1'b1);
    rd_q[0] = 16'hCAFE;
    do_req("resp_at_limit", 1'b0, 1'b0, 2'd0, 16'h3000, 16'h0000);
    checks++; if (rerr !== 2'b00 || rdat !== 16'hCAFE || lat !== 10) begin errors++; $display("FAIL resp_at_limit: err=%b rdata=%h lat=%0d want 00 CAFE 10", rerr, rdat, lat); end
  endtask

  task automatic test_reset_mid_write();
    int guard;
    int pulses;
    clear_log(0, 1'b0);
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_ind = 2'd0;
    req_addr  = 16'h2000; req_wdata = 16'hA5A5;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!mem_write && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_mid_write strobe: got %b want 1", mem_write); end
    repeat (2) @(negedge clk);
    pulses = resp_pulses;
    rst = 1'b1;
    #1;
    checks++; if (mem_write !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_write abort: write=%b ready=%b want 0 1", mem_write, req_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (resp_pulses !== pulses || mem_write !== 1'b0) begin errors++; $display("FAIL rst_mid_write no_resp: pulses=%0d write=%b want %0d 0", resp_pulses, mem_write, pulses); end
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_ind = 2'd0;
    req_addr = 16'h0000; req_wdata = 16'h0000;
    mem_rdata = 16'h0000; mem_resp = 1'b0;
    waits = 0; resp_on = 1'b1; rd_idx = 0; wcnt = 0; acc_n = 0;
    strobe_cyc = 0; both_hi = 0; resp_pulses = 0;
    for (int i = 0; i < 8; i++) rd_q[i] = 16'h0000;
    test_reset();
    test_word_load();
    test_byte_store();
    test_byte_load();
    test_indirect();
    test_misalign();
    test_timeout();
    test_reset_mid_write();
    checks++; if (both_hi !== 0) begin errors++; $display("FAIL strobe_exclusive: read&write seen %0d cycles want 0", both_hi); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
